// File: rtl/lb_target_responder.sv
// lb_target_responder: local-bus target with three R/W registers and a
// read-only ID register. It accepts a start, inserts wait states, then
// acknowledges or signals an error. It also handles 32-bit and 16-bit port
// byte lanes.
// Ports:
//   CLK40, RESET           - bus clock, synchronous active-high reset
//   TSn, SEL               - transfer start (active low), address decode hit
//   RnW, SIZ, A_AMIGA      - direction, size, byte address of the transfer
//   REG_ADDR               - register index 0-3
//   D_IN                   - write data lanes
//   D_OUT, D_OE            - read data and its output enable
//   TACKn, TEAn            - acknowledge / error strobes (active low)
//   PORTSIZE               - 1 while a 16-bit port is responding
module lb_target_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter bit          PORT16      = 1'b1,
  parameter logic [31:0] ID_VALUE    = 32'hA0C0_0111
) (
  input  logic        CLK40,
  input  logic        RESET,
  input  logic        TSn,
  input  logic        SEL,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  A_AMIGA,
  input  logic [1:0]  REG_ADDR,
  input  logic [31:0] D_IN,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  output logic        TACKn,
  output logic        TEAn,
  output logic        PORTSIZE
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NREG    = 3;
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [1:0]       siz_q, siz_d;
  logic [1:0]       a_q, a_d;
  logic [1:0]       ra_q, ra_d;
  logic [31:0]      regs_q [NREG];

  logic             bad_c;
  logic [31:0]      rd_word_c;
  logic [31:0]      rd_mask_c;
  logic [31:0]      wr_mask_c;
  logic [31:0]      wr_data_c;
  logic [31:0]      dout_d;
  logic             active_d;

  // Register bytes touched by an access; 16-bit port maps a half by A[1].
  function automatic logic [3:0] byte_en(input logic [1:0] siz, input logic [1:0] a);
    logic [1:0] half;
    logic [3:0] be;
    half = 2'b11;
    be   = 4'b1111;
    if (PORT16) begin
      if (siz == 2'b01) half = a[0] ? 2'b01 : 2'b10;
      be = a[1] ? {2'b00, half} : {half, 2'b00};
    end else begin
      case (siz)
        2'b01:   be = 4'b1000 >> a;
        2'b10:   be = a[1] ? 4'b0011 : 4'b1100;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Decode of illegal accesses at the accept edge.
  always_comb begin
    bad_c = 1'b0;
    if (SIZ == 2'b11) bad_c = 1'b1;
    if (SIZ == 2'b10 && A_AMIGA[0]) bad_c = 1'b1;
    if (SIZ == 2'b00 && A_AMIGA != 2'b00 && !PORT16) bad_c = 1'b1;
    if (!RnW && REG_ADDR == 2'd3) bad_c = 1'b1;
  end

  // Next-state and latched transfer attributes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    siz_d   = siz_q;
    a_d     = a_q;
    ra_d    = ra_q;
    case (state_q)
      IDLE: begin
        if (!TSn && SEL) begin
          rnw_d = RnW;
          siz_d = SIZ;
          a_d   = A_AMIGA;
          ra_d  = REG_ADDR;
          if (bad_c) begin
            state_d = ERR;
          end else if (WS_LOAD == '0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read path is computed from next-cycle attributes so data is ready in the first WAIT cycle.
  always_comb begin
    case (ra_d)
      2'd0:    rd_word_c = regs_q[0];
      2'd1:    rd_word_c = regs_q[1];
      2'd2:    rd_word_c = regs_q[2];
      default: rd_word_c = ID_VALUE;
    endcase
    rd_mask_c = lane_mask(byte_en(siz_d, a_d));
    active_d  = (state_d == WAIT) || (state_d == ACK);
    dout_d    = '0;
    if (active_d && rnw_d) begin
      if (PORT16) dout_d = a_d[1] ? {rd_word_c[15:0], 16'h0000} & {rd_mask_c[15:0], 16'h0000}
                                  : {rd_word_c[31:16], 16'h0000} & {rd_mask_c[31:16], 16'h0000};
      else        dout_d = rd_word_c & rd_mask_c;
    end
  end

  // Write path: 16-bit port replicates its lanes into both register halves.
  always_comb begin
    wr_mask_c = lane_mask(byte_en(siz_q, a_q));
    wr_data_c = PORT16 ? {D_IN[31:16], D_IN[31:16]} : D_IN;
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rnw_q    <= 1'b0;
      siz_q    <= '0;
      a_q      <= '0;
      ra_q     <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      D_OUT    <= '0;
      D_OE     <= 1'b0;
      TACKn    <= 1'b1;
      TEAn     <= 1'b1;
      PORTSIZE <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnw_q    <= rnw_d;
      siz_q    <= siz_d;
      a_q      <= a_d;
      ra_q     <= ra_d;
      D_OUT    <= dout_d;
      D_OE     <= active_d && rnw_d;
      TACKn    <= !(state_d == ACK);
      TEAn     <= !(state_d == ERR);
      PORTSIZE <= active_d && PORT16;
      // Write commits on the edge that ends the ACK cycle.
      if (state_q == ACK && !rnw_q) begin
        case (ra_q)
          2'd0:    regs_q[0] <= (regs_q[0] & ~wr_mask_c) | (wr_data_c & wr_mask_c);
          2'd1:    regs_q[1] <= (regs_q[1] & ~wr_mask_c) | (wr_data_c & wr_mask_c);
          2'd2:    regs_q[2] <= (regs_q[2] & ~wr_mask_c) | (wr_data_c & wr_mask_c);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lb_target_responder.sv
// Testbench for lb_target_responder: three instances (32-bit/2 waits,
// 16-bit/2 waits, 32-bit/0 waits) exercised from a directed vector table
// plus hand-written back-to-back, decode-miss and reset sequences.
module tb_lb_target_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [3];
  logic        tsn   [3];
  logic        sel   [3];
  logic        rnw   [3];
  logic [1:0]  siz   [3];
  logic [1:0]  a     [3];
  logic [1:0]  ra    [3];
  logic [31:0] din   [3];
  wire  [31:0] dout  [3];
  wire         doe   [3];
  wire         tackn [3];
  wire         tean  [3];
  wire         ps    [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    lb_target_responder #(
      .WAIT_STATES((g == 2) ? 0 : 2),
      .PORT16     ((g == 1) ? 1'b1 : 1'b0),
      .ID_VALUE   (32'hA0C0_0111)
    ) u_dut (
      .CLK40   (clk),
      .RESET   (reset[g]),
      .TSn     (tsn[g]),
      .SEL     (sel[g]),
      .RnW     (rnw[g]),
      .SIZ     (siz[g]),
      .A_AMIGA (a[g]),
      .REG_ADDR(ra[g]),
      .D_IN    (din[g]),
      .D_OUT   (dout[g]),
      .D_OE    (doe[g]),
      .TACKn   (tackn[g]),
      .TEAn    (tean[g]),
      .PORTSIZE(ps[g])
    );
  end

  typedef struct {
    int          inst;
    logic        rnw;
    logic [1:0]  siz;
    logic [1:0]  a;
    logic [1:0]  ra;
    logic [31:0] din;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int inst, input logic r, input logic [1:0] s,
                              input logic [1:0] ad, input logic [1:0] rg,
                              input logic [31:0] d, input logic e, input logic [31:0] x);
    vec_t v;
    v.inst = inst; v.rnw = r; v.siz = s; v.a = ad; v.ra = rg;
    v.din = d; v.err = e; v.exp = x;
    return v;
  endfunction

  // One transfer: start, check every cycle up to ACK/ERR, then one idle cycle.
  task automatic xact(input vec_t v, input int idx);
    int i, ws, last;
    logic p16, ok;
    i    = v.inst;
    ws   = (i == 2) ? 0 : 2;
    p16  = (i == 1);
    last = v.err ? 1 : ws + 1;
    ok   = !v.err;
    @(negedge clk);
    tsn[i] = 1'b0; sel[i] = 1'b1; rnw[i] = v.rnw; siz[i] = v.siz;
    a[i] = v.a; ra[i] = v.ra; din[i] = v.din;
    @(negedge clk);
    tsn[i] = 1'b1; sel[i] = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("v%0d c%0d tackn", idx, c), 32'(tackn[i]), 32'((ok && c == last) ? 1'b0 : 1'b1));
      chk($sformatf("v%0d c%0d tean", idx, c), 32'(tean[i]), 32'((!ok && c == last) ? 1'b0 : 1'b1));
      chk($sformatf("v%0d c%0d doe", idx, c), 32'(doe[i]), 32'(ok && v.rnw));
      chk($sformatf("v%0d c%0d portsize", idx, c), 32'(ps[i]), 32'(ok && p16));
      chk($sformatf("v%0d c%0d dout", idx, c), dout[i], (ok && v.rnw) ? v.exp : 32'h0);
    end
    @(negedge clk);
    chk($sformatf("v%0d idle tackn", idx), 32'(tackn[i]), 32'h1);
    chk($sformatf("v%0d idle tean", idx), 32'(tean[i]), 32'h1);
    chk($sformatf("v%0d idle doe", idx), 32'(doe[i]), 32'h0);
  endtask

  vec_t tbl[$];

  initial begin
    // inst 0: 32-bit port, 2 wait states
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'd0, 32'h1122_3344, 0, 32'h0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'd0, 32'h0,         0, 32'h1122_3344));
    tbl.push_back(mk(0, 0, 2'b01, 2'b10, 2'd1, 32'hFFFF_ABFF, 0, 32'h0));
    tbl.push_back(mk(0, 1, 2'b10, 2'b10, 2'd1, 32'h0,         0, 32'h0000_AB00));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'd1, 32'h0,         0, 32'h0000_AB00));
    tbl.push_back(mk(0, 0, 2'b11, 2'b00, 2'd0, 32'hDEAD_BEEF, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2'b10, 2'b01, 2'd0, 32'hDEAD_BEEF, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'd3, 32'hDEAD_BEEF, 1, 32'h0));
    tbl.push_back(mk(0, 0, 2'b00, 2'b10, 2'd0, 32'hDEAD_BEEF, 1, 32'h0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'd0, 32'h0,         0, 32'h1122_3344));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'd3, 32'h0,         0, 32'hA0C0_0111));
    tbl.push_back(mk(0, 1, 2'b01, 2'b00, 2'd0, 32'h0,         0, 32'h1100_0000));
    tbl.push_back(mk(0, 1, 2'b01, 2'b11, 2'd0, 32'h0,         0, 32'h0000_0044));
    tbl.push_back(mk(0, 0, 2'b10, 2'b00, 2'd1, 32'h5566_7777, 0, 32'h0));
    tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'd1, 32'h0,         0, 32'h5566_AB00));
    // inst 1: 16-bit port, 2 wait states
    tbl.push_back(mk(1, 0, 2'b10, 2'b10, 2'd2, 32'hBEEF_0000, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b10, 2'b10, 2'd2, 32'h0,         0, 32'hBEEF_0000));
    tbl.push_back(mk(1, 1, 2'b10, 2'b00, 2'd2, 32'h0,         0, 32'h0000_0000));
    tbl.push_back(mk(1, 0, 2'b01, 2'b01, 2'd2, 32'h1234_5678, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'b00, 2'b00, 2'd2, 32'h0,         0, 32'h0034_0000));
    tbl.push_back(mk(1, 1, 2'b01, 2'b11, 2'd2, 32'h0,         0, 32'h00EF_0000));
    tbl.push_back(mk(1, 1, 2'b01, 2'b10, 2'd2, 32'h0,         0, 32'hBE00_0000));
    tbl.push_back(mk(1, 1, 2'b00, 2'b10, 2'd2, 32'h0,         0, 32'hBEEF_0000));
    tbl.push_back(mk(1, 1, 2'b10, 2'b00, 2'd3, 32'h0,         0, 32'hA0C0_0000));
    tbl.push_back(mk(1, 0, 2'b00, 2'b00, 2'd3, 32'h1111_1111, 1, 32'h0));
    // inst 2: 32-bit port, no wait states
    tbl.push_back(mk(2, 0, 2'b00, 2'b00, 2'd0, 32'hCAFE_F00D, 0, 32'h0));
    tbl.push_back(mk(2, 1, 2'b00, 2'b00, 2'd0, 32'h0,         0, 32'hCAFE_F00D));

    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; tsn[i] = 1'b1; sel[i] = 1'b0; rnw[i] = 1'b1;
      siz[i] = 2'b00; a[i] = 2'b00; ra[i] = 2'd0; din[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d tackn", i), 32'(tackn[i]), 32'h1);
      chk($sformatf("rst%0d tean", i), 32'(tean[i]), 32'h1);
      chk($sformatf("rst%0d doe", i), 32'(doe[i]), 32'h0);
      chk($sformatf("rst%0d portsize", i), 32'(ps[i]), 32'h0);
      chk($sformatf("rst%0d dout", i), dout[i], 32'h0);
      reset[i] = 1'b0;
    end

    foreach (tbl[k]) xact(tbl[k], k);

    // Back-to-back on the zero-wait instance; a start during ACK is ignored.
    @(negedge clk);
    tsn[2] = 1'b0; sel[2] = 1'b1; rnw[2] = 1'b0; siz[2] = 2'b00; a[2] = 2'b00;
    ra[2] = 2'd1; din[2] = 32'h0102_0304;
    @(negedge clk);
    chk("b2b ack1 tackn", 32'(tackn[2]), 32'h0);
    ra[2] = 2'd2;
    @(negedge clk);
    chk("b2b ignored tackn", 32'(tackn[2]), 32'h1);
    chk("b2b ignored tean", 32'(tean[2]), 32'h1);
    rnw[2] = 1'b1; ra[2] = 2'd1;
    @(negedge clk);
    chk("b2b ack2 tackn", 32'(tackn[2]), 32'h0);
    chk("b2b ack2 doe", 32'(doe[2]), 32'h1);
    chk("b2b ack2 dout", dout[2], 32'h0102_0304);
    tsn[2] = 1'b1; sel[2] = 1'b0;
    @(negedge clk);
    chk("b2b idle tackn", 32'(tackn[2]), 32'h1);
    xact(mk(2, 1, 2'b00, 2'b00, 2'd2, 32'h0, 0, 32'h0), 100);

    // Start without decode hit is ignored.
    @(negedge clk);
    tsn[2] = 1'b0; sel[2] = 1'b0; rnw[2] = 1'b1;
    @(negedge clk);
    tsn[2] = 1'b1;
    chk("nosel tackn", 32'(tackn[2]), 32'h1);
    chk("nosel doe", 32'(doe[2]), 32'h0);

    // Reset wins over a start in the same cycle.
    @(negedge clk);
    reset[2] = 1'b1; tsn[2] = 1'b0; sel[2] = 1'b1; rnw[2] = 1'b1;
    @(negedge clk);
    reset[2] = 1'b0; tsn[2] = 1'b1; sel[2] = 1'b0;
    chk("rstpri tackn", 32'(tackn[2]), 32'h1);
    chk("rstpri doe", 32'(doe[2]), 32'h0);
    @(negedge clk);
    chk("rstpri next tackn", 32'(tackn[2]), 32'h1);

    // Reset during WAIT of a 16-bit write aborts the cycle.
    @(negedge clk);
    tsn[1] = 1'b0; sel[1] = 1'b1; rnw[1] = 1'b0; siz[1] = 2'b10; a[1] = 2'b00;
    ra[1] = 2'd0; din[1] = 32'h5555_0000;
    @(negedge clk);
    tsn[1] = 1'b1; sel[1] = 1'b0;
    chk("midrst wait portsize", 32'(ps[1]), 32'h1);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk("midrst tackn", 32'(tackn[1]), 32'h1);
    chk("midrst tean", 32'(tean[1]), 32'h1);
    chk("midrst doe", 32'(doe[1]), 32'h0);
    chk("midrst portsize", 32'(ps[1]), 32'h0);
    chk("midrst dout", dout[1], 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst after%0d tackn", c), 32'(tackn[1]), 32'h1);
    end
    xact(mk(1, 1, 2'b10, 2'b00, 2'd0, 32'h0, 0, 32'h0), 101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lb_target_responder.md
LB_TARGET_RESPONDER -- requirements
Module: lb_target_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- WAIT_STATES, 2: CLK40 cycles from accepted start to TACKn (0-15).
- PORT16, 1: 1 = 16-bit port on D[31:16], 0 = 32-bit port.
- ID_VALUE, 32'hA0C0_0111: read-only contents of register 3.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- CLK40 in 1: bus clock; all state changes on the rising edge.
- RESET in 1: synchronous, active-high reset.
- TSn in 1: transfer start, active low, one cycle wide.
- SEL in 1: address decode hit for this target, qualified by TSn.
- RnW in 1: 1 = read, 0 = write.
- SIZ in 2: 00 long, 01 byte, 10 word, 11 line.
- A_AMIGA in 2: byte address bits.
- REG_ADDR in 2: register index 0-3.
- D_IN in 32: write data, lanes UU=[31:24], UM=[23:16], LM=[15:8], LL=[7:0].
- D_OUT out 32: read data.
- D_OE out 1: read data output enable, active high.
- TACKn out 1: transfer acknowledge, active low.
- TEAn out 1: transfer error, active low.
- PORTSIZE out 1: 1 = 16-bit port is responding.
REQ-003 SHALL use one clock, CLK40, and a synchronous, active-high reset named RESET.

Function
REQ-004 SHALL implement states IDLE, WAIT, ACK and ERR.
REQ-005 In IDLE, SHALL accept a cycle when TSn=0 and SEL=1, and latch RnW, SIZ, A_AMIGA and REG_ADDR on that edge.
REQ-006 SHALL ignore TSn outside IDLE, and SHALL ignore TSn=0 with SEL=0.
REQ-007 On accept, SHALL go to ERR if any of the following holds:
- SIZ=11;
- word access with A_AMIGA[0]=1;
- long access with A_AMIGA!=00 while PORT16=0;
- write with REG_ADDR=3.
REQ-008 Otherwise SHALL go to WAIT, loading the wait counter with WAIT_STATES; with WAIT_STATES=0, SHALL go directly to ACK.
REQ-009 In WAIT, SHALL decrement the counter each cycle and enter ACK on the cycle after the counter reaches 1, so TACKn is first low exactly WAIT_STATES+1 cycles after the accept edge.
REQ-010 ACK and ERR SHALL each last exactly one cycle, then return to IDLE; TACKn and TEAn SHALL never be low in the same cycle.
REQ-011 SHALL drive TACKn=0 only in ACK and TEAn=0 only in ERR.
REQ-012 SHALL drive PORTSIZE=PORT16 in WAIT and ACK, and 0 otherwise.
REQ-013 For reads, SHALL drive D_OE=1 in WAIT and ACK, with D_OUT valid from the first WAIT cycle (or from ACK when WAIT_STATES=0).
REQ-014 SHALL keep D_OE=0 for writes, in ERR and in IDLE, and SHALL drive D_OUT=0 when D_OE=0.
REQ-015 32-bit port SHALL use these byte lanes:
- byte: lane UU/UM/LM/LL for A_AMIGA 00/01/10/11;
- word: A_AMIGA[1]=0 gives UU+UM, A_AMIGA[1]=1 gives LM+LL;
- long: all four lanes.
REQ-016 16-bit port SHALL use these byte lanes:
- data on D[31:16] only;
- A_AMIGA[1] selects the register half (0 = [31:16], 1 = [15:0]);
- byte: A_AMIGA[0] selects UU (0) or UM (1);
- word and long: both UU and UM, with long treated as a word at A_AMIGA[1].
REQ-017 For writes, SHALL update only the selected register bytes, taking data from the matching D_IN lanes sampled on the ACK edge; unselected bytes SHALL be retained.
REQ-018 For reads, SHALL present the selected register bytes on their lanes and drive 0 on unselected lanes.
REQ-019 Register 3 SHALL read as ID_VALUE; registers 0-2 SHALL be read/write, 32 bits each.
REQ-020 An ERR cycle SHALL NOT modify any register.
REQ-021 A new start SHALL be accepted on the first IDLE cycle after ACK or ERR, giving back-to-back cycles with one idle cycle between them.

Reset
REQ-022 With RESET=1, SHALL set:
- state IDLE;
- TACKn=1, TEAn=1, PORTSIZE=0, D_OE=0, D_OUT=0;
- registers 0-2 to 0.
REQ-023 Reset asserted mid-cycle SHALL abort the cycle with no TACKn or TEAn and no register write; RESET SHALL take priority over TSn in the same cycle.

Verification
REQ-024 The bench SHALL cover the following scenarios.
- PORT16=0, WAIT_STATES=2, long write 0x11223344 to reg 0, then long read: TACKn low on cycle 3 after accept; read returns 0x11223344 with D_OE high for 3 cycles.
- PORT16=0, byte write 0xAB at A=10 to reg 1 (reg1 previously 0): reg1=0x0000AB00; word read at A=10 returns D_OUT=0x0000AB00.
- PORT16=1, word write 0xBEEF at A=10 to reg 2: reg2[15:0]=0xBEEF; PORTSIZE=1 during WAIT and ACK; read data appears on D[31:16]=0xBEEF.
- Error cases: SIZ=11, word at A=01, and write to reg 3 each give TEAn low for exactly 1 cycle, TACKn stays high and registers are unchanged; a read of reg 3 returns 0xA0C00111.
- WAIT_STATES=0 with back-to-back starts: TACKn low the cycle after accept; a second TSn during ACK is ignored; a TSn on the following IDLE cycle is accepted.
- RESET asserted during WAIT of a write: no TACKn, target register unchanged; all outputs at reset values on the next cycle.
